// File: rtl/ps2_kbd_rx_pkg.sv
// Shared definitions for the PS/2 keyboard receiver: FSM states, frame shape, defaults.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ps2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } ps2_state_t;

    localparam int FRAME_BITS = 11;   // start + 8 data + parity + stop
    localparam int DATA_BITS  = 8;
    localparam bit ODD_PARITY = 1'b1; // data ones plus parity bit must be odd

    localparam int DEF_FILTER_LEN     = 8;
    localparam int DEF_TIMEOUT_CYCLES = 50000;
    localparam int DEF_FIFO_AW        = 3;

    // True when the data byte and its parity bit satisfy odd parity.
    function automatic logic parity_ok(input logic [DATA_BITS-1:0] d, input logic p);
        return (^{d, p}) == ODD_PARITY;
    endfunction

endpackage

// File: rtl/ps2_kbd_rx_if.sv
// Byte handshake between the PS/2 receiver and the keyboard port of the I/O bus.
// Latency: n/a (wires only).
// Backpressure: consumer holds rx_ready low; the producer keeps rx_data/rx_valid stable.
interface ps2_kbd_rx_if;
    import ps2_pkg::*;

    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_ready;

    modport master (output rx_data, output rx_valid, input rx_ready);
    modport slave  (input rx_data, input rx_valid, output rx_ready);
endinterface

// File: rtl/ps2_kbd_rx_fifo.sv
// Generic synchronous FIFO with an overflow pulse for pushes that find it full.
// Latency: one cycle from push to non-empty; dout is combinational from the head entry.
// Backpressure: push while full (and no pop) drops the word; pop while empty is ignored.
module ps2_rx_fifo
    import ps2_pkg::*;
#(
    parameter int W  = DATA_BITS,
    parameter int AW = DEF_FIFO_AW
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty,
    output logic         overflow
);
    localparam int             DEPTH    = 2**AW;
    localparam logic [AW:0]    FULL_CNT = (AW+1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign do_pop  = pop & ~empty;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign do_push = push & (~full | do_pop);
    assign dout    = empty ? '0 : mem[rd_ptr];

    // Storage array: written only when the push is accepted.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    // Pointers wrap naturally at AW bits; count tracks occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            overflow <= push & full & ~do_pop;
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard receiver: sync + deglitch ps2_clk, deserialise 11-bit frames, buffer good bytes.
// Latency: byte valid 2 + FILTER_LEN + 2 clk after the raw stop-bit falling edge.
// Backpressure: rx_ready low fills the buffer (FIFO if PS2_KBD_FIFO_EN, else one entry); extra bytes drop with overflow.
module ps2_kbd_rx
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = DEF_FILTER_LEN,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int FIFO_AW        = DEF_FIFO_AW
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         ps2_clk,
    input  logic         ps2_data,
    ps2_kbd_rx_if.master rx,
    output logic         parity_err,
    output logic         frame_err,
    output logic         overflow,
    output logic         busy
);
    localparam int               FCW      = $clog2(FILTER_LEN);
    localparam logic [FCW-1:0]   FCNT_MAX = FCW'(FILTER_LEN - 1);
    localparam int               WDW      = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WDW-1:0]   WD_LAST  = WDW'(TIMEOUT_CYCLES - 1);
    localparam logic [2:0]       LAST_BIT = 3'(DATA_BITS - 1);

    logic [1:0]           clk_sync;
    logic [1:0]           data_sync;
    logic [FCW-1:0]       filt_cnt;
    logic                 filt_clk;
    logic                 filt_prev;
    logic                 fall;
    ps2_state_t           state;
    logic [2:0]           bit_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_bit;
    logic [WDW-1:0]       wdog;
    logic                 push;

    // Two-flop synchronisers; idle PS/2 lines sit high.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clk_sync  <= 2'b11;
            data_sync <= 2'b11;
        end else begin
            clk_sync  <= {clk_sync[0], ps2_clk};
            data_sync <= {data_sync[0], ps2_data};
        end
    end

    // Filtered clock flips only after FILTER_LEN consecutive samples disagree with it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            filt_cnt  <= '0;
            filt_clk  <= 1'b1;
            filt_prev <= 1'b1;
        end else begin
            filt_prev <= filt_clk;
            if (clk_sync[1] == filt_clk) begin
                filt_cnt <= '0;
            end else if (filt_cnt == FCNT_MAX) begin
                filt_clk <= clk_sync[1];
                filt_cnt <= '0;
            end else begin
                filt_cnt <= filt_cnt + 1'b1;
            end
        end
    end

    assign fall = filt_prev & ~filt_clk;
    assign busy = (state != ST_IDLE);

    // Frame FSM with watchdog; pulses and push are registered and last one cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            bit_cnt    <= '0;
            shreg      <= '0;
            par_bit    <= 1'b0;
            wdog       <= '0;
            push       <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            push       <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            if (state == ST_IDLE || fall) wdog <= '0;
            else                          wdog <= wdog + 1'b1;

            if (state != ST_IDLE && !fall && wdog == WD_LAST) begin
                // Device stalled mid-frame: abandon the partial byte.
                state     <= ST_IDLE;
                frame_err <= 1'b1;
                wdog      <= '0;
            end else if (fall) begin
                case (state)
                    ST_IDLE: begin
                        if (data_sync[1] == 1'b0) begin
                            state   <= ST_DATA;
                            bit_cnt <= '0;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end
                    ST_DATA: begin
                        shreg <= {data_sync[1], shreg[DATA_BITS-1:1]};
                        if (bit_cnt == LAST_BIT) state <= ST_PARITY;
                        else                     bit_cnt <= bit_cnt + 1'b1;
                    end
                    ST_PARITY: begin
                        par_bit <= data_sync[1];
                        state   <= ST_STOP;
                    end
                    default: begin
                        state <= ST_IDLE;
                        if (data_sync[1] == 1'b0)        frame_err  <= 1'b1;
                        else if (!parity_ok(shreg, par_bit)) parity_err <= 1'b1;
                        else                             push       <= 1'b1;
                    end
                endcase
            end
        end
    end

`ifdef PS2_KBD_FIFO_EN
    logic fifo_empty;
    logic fifo_full_unused;

    ps2_rx_fifo #(.W(DATA_BITS), .AW(FIFO_AW)) u_fifo (
        .clk      (clk),
        .rst      (reset),
        .push     (push),
        .din      (shreg),
        .pop      (rx.rx_valid & rx.rx_ready),
        .dout     (rx.rx_data),
        .full     (fifo_full_unused),
        .empty    (fifo_empty),
        .overflow (overflow)
    );

    assign rx.rx_valid = ~fifo_empty;
`else
    logic                 hold_vld;
    logic [DATA_BITS-1:0] hold_dat;
    logic                 accept;
    logic                 unused_aw;

    assign unused_aw   = ^FIFO_AW;
    assign accept      = hold_vld & rx.rx_ready;
    assign rx.rx_valid = hold_vld;
    assign rx.rx_data  = hold_dat;

    // One-entry holding register; a same-cycle accept frees it for the new byte.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_vld <= 1'b0;
            hold_dat <= '0;
            overflow <= 1'b0;
        end else begin
            overflow <= 1'b0;
            if (push) begin
                if (!hold_vld || accept) begin
                    hold_dat <= shreg;
                    hold_vld <= 1'b1;
                end else begin
                    overflow <= 1'b1;
                end
            end else if (accept) begin
                hold_vld <= 1'b0;
            end
        end
    end
`endif
endmodule

// File: tb/tb_ps2_kbd_rx.sv
// Directed bench for ps2_kbd_rx: frames, parity/frame errors, timeout, overflow, glitches, reset.
// Latency: byte expected a few cycles after each frame's stop bit.
// Backpressure: rx_ready driven by the stimulus to exercise buffering and overflow.
module tb_ps2_kbd_rx;
    import ps2_pkg::*;

    localparam int FL = 4;
    localparam int TO = 300;
    localparam int AW = 3;
    localparam int HP = 20;

    logic clk      = 1'b0;
    logic reset    = 1'b1;
    logic ps2_clk  = 1'b1;
    logic ps2_data = 1'b1;
    logic parity_err, frame_err, overflow, busy;

    ps2_kbd_rx_if bus();

    ps2_kbd_rx #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO), .FIFO_AW(AW)) dut (
        .clk        (clk),
        .reset      (reset),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .rx         (bus),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .overflow   (overflow),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int n_perr = 0, n_ferr = 0, n_ovf = 0, n_vld = 0, cyc = 0;
    logic [7:0] got[$];
    int acc_cyc[$];

    // Observe outputs on the falling edge, away from the DUT's active edge.
    always @(negedge clk) begin
        cyc++;
        if (!reset) begin
            if (parity_err) n_perr++;
            if (frame_err)  n_ferr++;
            if (overflow)   n_ovf++;
            if (bus.rx_valid) n_vld++;
            if (bus.rx_valid && bus.rx_ready) begin
                got.push_back(bus.rx_data);
                acc_cyc.push_back(cyc);
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clr();
        n_perr = 0; n_ferr = 0; n_ovf = 0; n_vld = 0;
        got.delete();
        acc_cyc.delete();
    endtask

    // Send the first nbits of a frame; gl inserts sub-filter glitches in both clock phases.
    task automatic send_frame(input logic [7:0] b, input logic pflip, input logic stopb,
                              input int nbits, input bit gl);
        logic [FRAME_BITS-1:0] f;
        f = {stopb, (~^b) ^ pflip, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2_data = f[i];
            if (gl && i == 4) begin
                tick(HP/2); ps2_clk = 1'b0; tick(FL-1); ps2_clk = 1'b1; tick(HP/2 - (FL-1));
            end else begin
                tick(HP);
            end
            ps2_clk = 1'b0;
            if (gl && i == 6) begin
                tick(HP/2); ps2_clk = 1'b1; tick(FL-1); ps2_clk = 1'b0; tick(HP/2 - (FL-1));
            end else begin
                tick(HP);
            end
            ps2_clk = 1'b1;
        end
        tick(HP);
    endtask

    task automatic expect_one(input string tag, input logic [7:0] b);
        check({tag, "_cnt"}, got.size(), 1);
        if (got.size() > 0) check({tag, "_byte"}, got[0], b);
    endtask

    initial begin
        bus.rx_ready = 1'b0;
        tick(3);
        check("rst_valid", bus.rx_valid, 0);
        check("rst_busy", busy, 0);
        reset = 1'b0;
        tick(3);
        check("rst_data", bus.rx_data, 0);
        check("rst_errs", {parity_err, frame_err, overflow, busy}, 0);

        // 1: clean frame with consumer ready
        clr(); bus.rx_ready = 1'b1;
        send_frame(8'h1C, 1'b0, 1'b1, FRAME_BITS, 1'b0);
        expect_one("t1", 8'h1C);
        check("t1_vld_cycles", n_vld, 1);
        check("t1_errs", n_perr + n_ferr + n_ovf, 0);

        // 2: bad parity, then a good frame
        clr();
        send_frame(8'h1C, 1'b1, 1'b1, FRAME_BITS, 1'b0);
        check("t2_perr", n_perr, 1);
        check("t2_novalid", n_vld, 0);
        send_frame(8'hF0, 1'b0, 1'b1, FRAME_BITS, 1'b0);
        expect_one("t2", 8'hF0);
        check("t2_ferr", n_ferr, 0);

        // 3: partial frame abandoned by the watchdog
        clr();
        send_frame(8'h00, 1'b0, 1'b1, 5, 1'b0);
        check("t3_busy_mid", busy, 1);
        tick(TO + 10);
        check("t3_ferr", n_ferr, 1);
        check("t3_busy_after", busy, 0);
        check("t3_nobyte", got.size(), 0);
        send_frame(8'h29, 1'b0, 1'b1, FRAME_BITS, 1'b0);
        expect_one("t3", 8'h29);

        // 4: fill the buffer with the consumer stalled, then drain
        clr(); bus.rx_ready = 1'b0;
        for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b0, 1'b1, FRAME_BITS, 1'b0);
        check("t4_held_valid", bus.rx_valid, 1);
        check("t4_nodrain", got.size(), 0);
`ifdef PS2_KBD_FIFO_EN
        check("t4_ovf", n_ovf, 1);
        bus.rx_ready = 1'b1;
        tick(20);
        check("t4_cnt", got.size(), 8);
        for (int i = 0; i < 8; i++)
            if (i < got.size()) check("t4_order", got[i], i + 1);
        if (acc_cyc.size() == 8) check("t4_back2back", acc_cyc[7] - acc_cyc[0], 7);
`else
        check("t4_ovf", n_ovf, 8);
        bus.rx_ready = 1'b1;
        tick(20);
        expect_one("t4", 8'h01);
`endif
        check("t4_empty", bus.rx_valid, 0);

        // 5: glitches shorter than the filter, idle and mid-frame
        clr();
        ps2_clk = 1'b0; tick(FL-1); ps2_clk = 1'b1; tick(20);
        check("t5_idle_busy", busy, 0);
        send_frame(8'h3A, 1'b0, 1'b1, FRAME_BITS, 1'b1);
        expect_one("t5", 8'h3A);
        check("t5_errs", n_perr + n_ferr + n_ovf, 0);

        // 6: reset in the middle of a frame
        clr(); bus.rx_ready = 1'b0;
        send_frame(8'h77, 1'b0, 1'b1, FRAME_BITS, 1'b0);
        check("t6_pre_valid", bus.rx_valid, 1);
        send_frame(8'hC3, 1'b0, 1'b1, 5, 1'b0);
        check("t6_pre_busy", busy, 1);
        reset = 1'b1;
        #1;
        check("t6_rst_outs", {bus.rx_valid, parity_err, frame_err, overflow, busy}, 0);
        check("t6_rst_data", bus.rx_data, 0);
        tick(3);
        reset = 1'b0;
        tick(3);
        clr(); bus.rx_ready = 1'b1;
        send_frame(8'h5A, 1'b0, 1'b1, FRAME_BITS, 1'b0);
        expect_one("t6", 8'h5A);
        check("t6_errs", n_perr + n_ferr + n_ovf, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
